// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared defaults for the synchronous FIFO controller and its users.
package fifo_pkg;

    // Default geometry: 16-entry FIFO with flags two entries from each end.
    localparam int FIFO_ADDRSIZE_DEF = 4;
    localparam int FIFO_AFULL_DEF    = 14;
    localparam int FIFO_AEMPTY_DEF   = 2;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the FIFO controller.
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = FIFO_ADDRSIZE_DEF
) ();

    logic                push;
    logic                pop;
    logic                wclken;
    logic [ADDRSIZE-1:0] waddr;
    logic                wfull;
    logic                rclken;
    logic [ADDRSIZE-1:0] raddr;
    logic                rempty;
    logic [ADDRSIZE:0]   count;
    logic                almost_full;
    logic                almost_empty;
    logic                overflow;
    logic                underflow;

    // The FIFO user issues requests and observes memory controls and status.
    modport master (
        output push, pop,
        input  wclken, waddr, wfull, rclken, raddr, rempty,
        input  count, almost_full, almost_empty, overflow, underflow
    );

    // The controller receives requests and produces memory controls and status.
    modport slave (
        input  push, pop,
        output wclken, waddr, wfull, rclken, raddr, rempty,
        output count, almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ctrl_ptr.sv
// Wrapping (ADDRSIZE+1)-bit pointer; the extra MSB distinguishes full from empty.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = FIFO_ADDRSIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [ADDRSIZE-1:0] addr,
    output logic [ADDRSIZE:0]   ptr_nxt
);

    localparam logic [ADDRSIZE:0] ONE = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0] ptr;

    // Next-state value, exposed so status flags can be registered alongside the pointer.
    always_comb begin
        ptr_nxt = ptr;
        if (rst) begin
            ptr_nxt = '0;
        end else if (en) begin
            ptr_nxt = ptr + ONE;
        end
    end

    // Pointer register: cleared by reset, advances only on an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + ONE;
        end
    end

    assign addr = ptr[ADDRSIZE-1:0];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, handshake and status for an external dual-port RAM.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE   = FIFO_ADDRSIZE_DEF,
    parameter int AFULL_LVL  = FIFO_AFULL_DEF,
    parameter int AEMPTY_LVL = FIFO_AEMPTY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);

    logic                wclken;
    logic                rclken;
    logic [ADDRSIZE:0]   wptr_p0;
    logic [ADDRSIZE:0]   rptr_p0;
    logic [ADDRSIZE:0]   cnt_p0;
    logic                rempty_p0;
    logic                wfull_p0;
    logic                af_p0;
    logic                ae_p0;

    logic [ADDRSIZE:0]   cnt_p1;
    logic                rempty_p1;
    logic                wfull_p1;
    logic                af_p1;
    logic                ae_p1;
    logic                ovf_p1;
    logic                unf_p1;

    // Requests are gated by the registered flags, so a full FIFO still accepts
    // a pop and an empty one still accepts a push in the same cycle.
    assign wclken = bus.push & ~wfull_p1  & ~rst;
    assign rclken = bus.pop  & ~rempty_p1 & ~rst;

    fifo_ptr #(.ADDRSIZE(ADDRSIZE)) u_wptr (
        .clk     (clk),
        .rst     (rst),
        .en      (wclken),
        .addr    (bus.waddr),
        .ptr_nxt (wptr_p0)
    );

    fifo_ptr #(.ADDRSIZE(ADDRSIZE)) u_rptr (
        .clk     (clk),
        .rst     (rst),
        .en      (rclken),
        .addr    (bus.raddr),
        .ptr_nxt (rptr_p0)
    );

    // Status derived from next-state pointers so it lines up with the pointer registers.
    always_comb begin
        cnt_p0    = wptr_p0 - rptr_p0;
        rempty_p0 = (wptr_p0 == rptr_p0);
        wfull_p0  = (wptr_p0[ADDRSIZE] != rptr_p0[ADDRSIZE]) &&
                    (wptr_p0[ADDRSIZE-1:0] == rptr_p0[ADDRSIZE-1:0]);
        af_p0     = (32'(cnt_p0) >= AFULL_LVL);
        ae_p0     = (32'(cnt_p0) <= AEMPTY_LVL);
    end

    // ---- stage p0 -> p1: registered occupancy and threshold flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1    <= '0;
            rempty_p1 <= 1'b1;
            wfull_p1  <= 1'b0;
            af_p1     <= 1'b0;
            ae_p1     <= 1'b1;
        end else begin
            cnt_p1    <= cnt_p0;
            rempty_p1 <= rempty_p0;
            wfull_p1  <= wfull_p0;
            af_p1     <= af_p0;
            ae_p1     <= ae_p0;
        end
    end

    // Sticky error flags: any rejected push/pop is remembered until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_p1 <= 1'b0;
            unf_p1 <= 1'b0;
        end else begin
            ovf_p1 <= ovf_p1 | (bus.push & wfull_p1);
            unf_p1 <= unf_p1 | (bus.pop  & rempty_p1);
        end
    end

    assign bus.wclken       = wclken;
    assign bus.rclken       = rclken;
    assign bus.wfull        = wfull_p1;
    assign bus.rempty       = rempty_p1;
    assign bus.count        = cnt_p1;
    assign bus.almost_full  = af_p1;
    assign bus.almost_empty = ae_p1;
    assign bus.overflow     = ovf_p1;
    assign bus.underflow    = unf_p1;

endmodule
